step_scheduler: RTL

// - Sequences the snake game: decides when the snake advances one cell. Counts video frames,

---
 rtl/step_scheduler.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/step_scheduler.sv
// step_scheduler: paces the snake game. Counts video frames, issues a one-cycle
// step request to the snake datapath, waits for its completion handshake, keeps
// the score and step period, and latches game over.
// Optional feature macro: STEP_SPEEDUP_EN -- when defined, every FOODS_PER_LEVEL
// foods eaten shortens the step period by one frame, never below MIN_PERIOD.
// Without it the period stays at START_PERIOD and no food counter exists.
module step_scheduler #(
  parameter int unsigned START_PERIOD    = 12,
  parameter int unsigned MIN_PERIOD      = 3,
  parameter int unsigned FOODS_PER_LEVEL = 4,
  parameter int unsigned CNT_W           = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_frame,
  input  logic             i_start,
  input  logic             i_step_done,
  input  logic             i_grow,
  input  logic             i_collision,
  output logic             o_step,
  output logic             o_busy,
  output logic             o_game_over,
  output logic [CNT_W-1:0] o_period,
  output logic [7:0]       o_score
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_STEP = 2'd2,
    S_OVER = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LP_START = START_PERIOD[CNT_W-1:0];

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [CNT_W-1:0] w_frame_cnt_next;
  logic             r_pending;
  logic             w_pending_next;
  logic             r_collided;
  logic             w_collided_next;
  logic             r_step;
  logic             w_step_next;
  logic             r_busy;
  logic             r_game_over;
  logic [7:0]       r_score;
  logic [7:0]       w_score_next;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] w_period_next;
  logic             w_grow_acc;
  logic [CNT_W:0]   w_cnt_inc;
  logic             w_frame_hit;

  // One extra bit so the incremented count can never wrap before the compare.
  assign w_cnt_inc   = {1'b0, r_frame_cnt} + {{CNT_W{1'b0}}, 1'b1};
  // A frame completes the period when the count would reach it; ">=" keeps a
  // freshly shortened period from being overrun by an older, larger count.
  assign w_frame_hit = i_frame && (w_cnt_inc >= {1'b0, r_period});

  // Next-state and next-value logic for the sequencing FSM.
  always_comb begin
    w_state_next     = r_state;
    w_frame_cnt_next = r_frame_cnt;
    w_pending_next   = r_pending;
    w_collided_next  = r_collided;
    w_step_next      = 1'b0;
    w_score_next     = r_score;
    w_grow_acc       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_next     = S_WAIT;
          w_frame_cnt_next = '0;
        end
      end
      S_WAIT: begin
        if (r_pending || w_frame_hit) begin
          w_state_next     = S_STEP;
          w_step_next      = 1'b1;
          w_frame_cnt_next = '0;
          w_pending_next   = 1'b0;
          w_collided_next  = 1'b0;
        end else if (i_frame) begin
          w_frame_cnt_next = w_cnt_inc[CNT_W-1:0];
        end
      end
      S_STEP: begin
        // Only one overrun step is remembered; once pending the count parks at 0.
        if (i_frame && !r_pending) begin
          if (w_frame_hit) begin
            w_pending_next   = 1'b1;
            w_frame_cnt_next = '0;
          end else begin
            w_frame_cnt_next = w_cnt_inc[CNT_W-1:0];
          end
        end
        if (i_grow) begin
          w_grow_acc = 1'b1;
          if (r_score != 8'hFF) begin
            w_score_next = r_score + 8'd1;
          end
        end
        if (i_collision) begin
          w_collided_next = 1'b1;
        end
        if (i_step_done) begin
          w_state_next = (r_collided || i_collision) ? S_OVER : S_WAIT;
        end
      end
      S_OVER: begin
        w_state_next = S_OVER;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; busy/game-over follow the state being entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_frame_cnt <= '0;
      r_pending   <= 1'b0;
      r_collided  <= 1'b0;
      r_step      <= 1'b0;
      r_busy      <= 1'b0;
      r_game_over <= 1'b0;
      r_score     <= 8'd0;
      r_period    <= LP_START;
    end else begin
      r_state     <= w_state_next;
      r_frame_cnt <= w_frame_cnt_next;
      r_pending   <= w_pending_next;
      r_collided  <= w_collided_next;
      r_step      <= w_step_next;
      r_busy      <= (w_state_next == S_STEP);
      r_game_over <= (w_state_next == S_OVER);
      r_score     <= w_score_next;
      r_period    <= w_period_next;
    end
  end

`ifdef STEP_SPEEDUP_EN
  localparam int unsigned      LP_FOOD_W   = (FOODS_PER_LEVEL > 1) ? $clog2(FOODS_PER_LEVEL) : 1;
  localparam logic [LP_FOOD_W:0] LP_FOOD_TGT = FOODS_PER_LEVEL[LP_FOOD_W:0];
  localparam logic [CNT_W-1:0] LP_MIN      = MIN_PERIOD[CNT_W-1:0];

  logic [LP_FOOD_W-1:0] r_food_cnt;
  logic [LP_FOOD_W-1:0] w_food_cnt_next;
  logic [LP_FOOD_W:0]   w_food_inc;

  assign w_food_inc = {1'b0, r_food_cnt} + {{LP_FOOD_W{1'b0}}, 1'b1};

  // Level-up: every FOODS_PER_LEVEL foods shave one frame off the period, floored.
  always_comb begin
    w_food_cnt_next = r_food_cnt;
    w_period_next   = r_period;
    if (w_grow_acc) begin
      if (w_food_inc == LP_FOOD_TGT) begin
        w_food_cnt_next = '0;
        if (r_period > LP_MIN) begin
          w_period_next = r_period - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end else begin
        w_food_cnt_next = w_food_inc[LP_FOOD_W-1:0];
      end
    end
  end

  // Food counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_food_cnt <= '0;
    end else begin
      r_food_cnt <= w_food_cnt_next;
    end
  end
`else
  // Fixed pace: the period register simply holds its reset value.
  assign w_period_next = r_period;

  // Speed-up parameters are accepted for interface compatibility only; this
  // empty scope just marks a configuration that would be illegal with speed-up.
  if ((FOODS_PER_LEVEL == 0) || (MIN_PERIOD == 0)) begin : g_speedup_cfg_ignored
  end

  logic w_grow_unused;
  assign w_grow_unused = w_grow_acc;
`endif

  assign o_step      = r_step;
  assign o_busy      = r_busy;
  assign o_game_over = r_game_over;
  assign o_period    = r_period;
  assign o_score     = r_score;

endmodule
